// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with carry/borrow, overflow and zero flags.
// Optional ADDSUB_SAT_EN: clamp the result to the signed limit on overflow.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int ND = WIDTH / DIGIT;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_mode, r_carry, r_cout, r_ovf, r_zero;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_da, w_db;
    logic [DIGIT:0]   w_sum;
    logic             w_last, w_cmsb, w_ovf;
    logic [WIDTH-1:0] w_res_nxt, w_res_fin;

    assign w_da   = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_db   = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_sum  = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(ND - 1));
    // Carry into the MSB is recovered from the top sum bit of the last digit.
    assign w_cmsb = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_sum[DIGIT-1];
    assign w_ovf  = w_cmsb ^ w_sum[DIGIT];

    always_comb begin
        w_res_nxt = r_res;
        w_res_nxt[int'(r_cnt) * DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
        w_res_fin = w_res_nxt;
`ifdef ADDSUB_SAT_EN
        if (w_ovf)
            w_res_fin = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b ^ {WIDTH{mode}};
                    r_mode  <= mode;
                    r_carry <= mode;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_carry <= w_sum[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res  <= w_res_fin;
                        r_cout <= w_sum[DIGIT] ^ r_mode;
                        r_ovf  <= w_ovf;
                        r_zero <= (w_res_fin == '0);
                    end else begin
                        r_res  <= w_res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_res;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor: next generation of the team's 1-bit full adder-subtractor. It takes WIDTH-bit operands with a mode select, processes DIGIT bits per clock LSB-first through a registered carry chain, and returns the result with carry/borrow, signed-overflow and zero flags. It sits between operand producers and result consumers behind valid/ready handshakes on both sides.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle. Must be ≥1. NUM_DIGITS = WIDTH/DIGIT.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- mode  input  1  0 = add (a+b), 1 = subtract (a−b).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum or difference.
- cout  output  1  add: carry-out; subtract: borrow (1 when a<b unsigned).
- ovf  output  1  two's-complement overflow.
- zero  output  1  result == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- in_ready = (state == IDLE), decoded from state; it reads 1 while rst_n is low.
- IDLE: on in_valid && in_ready, latch a, b XOR {WIDTH{mode}}, carry = mode, and digit counter = 0; go to RUN. a, b and mode are sampled only at acceptance.
- RUN: each cycle add digit k of A, digit k of B' and the carry register. Write DIGIT result bits into position k and update carry. On the last digit (k = NUM_DIGITS−1), also capture the carry into the MSB, compute the flags, and go to DONE.
- Flags:
  - cout = carry_out XOR mode.
  - ovf = carry into MSB XOR carry_out.
  - zero = (final result == 0).
- DONE: out_valid = 1. result and flags are held stable until out_valid && out_ready, then go to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Full-width arithmetic is modulo 2^WIDTH. No carry-in port.
- Reset, asynchronous at any state including mid-RUN:
  - state goes to IDLE, the in-flight operation is discarded, the counter is cleared.
  - result, cout, ovf, zero and out_valid all go to 0.

## Timing
- Acceptance edge E0. Digits are computed on edges E1..E_NUM_DIGITS. out_valid is high in the cycle after edge E_NUM_DIGITS, i.e. NUM_DIGITS cycles after acceptance (4 with defaults).
- Result handshake completes on the edge where out_valid && out_ready. in_ready is high the following cycle. There is no same-cycle bypass between output handshake and new acceptance.
- Minimum issue interval is NUM_DIGITS + 2 cycles with out_ready held high.
- DIGIT = WIDTH degenerates to one RUN cycle; behaviour is otherwise unchanged.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

## Configuration
- ADDSUB_SAT_EN defined: when ovf = 1, result is clamped to the signed limit in the direction of the true result:
  - 0111…1 if operand A's sign bit is 0.
  - 1000…0 if operand A's sign bit is 1.
  - ovf is still reported. zero is evaluated on the clamped value, so it is 0.
  - cout is unaffected.
- ADDSUB_SAT_EN undefined: result wraps modulo 2^WIDTH. No saturation logic is synthesised.

## Test plan (WIDTH=16, DIGIT=4)
- Add 0x1234 + 0x0001 -> result 0x1235, cout 0, ovf 0, zero 0; out_valid exactly 4 cycles after the acceptance edge.
- Subtract 0x0005 − 0x0007 -> result 0xFFFE, cout (borrow) 1, ovf 0, zero 0. Subtract 0x0003 − 0x0003 -> 0x0000, cout 0, zero 1.
- Add 0x7FFF + 0x0001 -> ovf 1; result 0x8000 without ADDSUB_SAT_EN, 0x7FFF with it. Subtract 0x8000 − 0x0001 -> ovf 1; result 0x7FFF without, 0x8000 with.
- Add 0xFFFF + 0x0001 -> result 0x0000, cout 1, ovf 0, zero 1.
- Backpressure: hold out_ready low 10 cycles in DONE and toggle in_valid and operands -> result and flags stable, in_ready 0. After out_ready, in_ready rises one cycle later; back-to-back issue interval is 6 cycles.
- Reset pulse during RUN (digit 2) -> out_valid, result and flags go to 0 immediately. After release, in_ready is 1 and a fresh operation completes correctly.
